// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Purpose:
//   Sequences bring-up and recovery of the on-chip PLL (27 MHz in, 120 MHz
//   out). It pulses the PLL RESET pin, waits for the asynchronous LOCK output,
//   and requires lock to stay continuously high for a programmed interval
//   before raising clk_ready. A lock that never arrives is retried a bounded
//   number of times, after which the block parks in FAULT until cleared.
//   Everything runs on the 27 MHz board clock, never on the PLL output, so
//   the supervisor keeps working while the PLL is unlocked or stopped.
//
// Parameters:
//   RST_PULSE_CYCLES    PLL reset pulse length in sys_clk cycles (>= 1)
//   LOCK_TIMEOUT_CYCLES cycles to wait for lock after reset release (>= 2)
//   STABLE_CYCLES       consecutive locked cycles required before ready (>= 1)
//   MAX_RETRIES         timeout-driven retries before FAULT (0..15)
//
// Ports:
//   sys_clk_i        27 MHz board clock, the only clock
//   sys_rst_i        asynchronous active-high reset
//   pll_lock_i       raw PLL LOCK (asynchronous, synchronized here)
//   force_relock_i   single-cycle request to reset and relock the PLL
//   fault_clear_i    single-cycle request to leave FAULT
//   pll_reset_o      PLL RESET pin, active-high
//   clk_ready_o      PLL clock valid, high exactly while in RUNNING
//   fault_o          retries exhausted, high exactly while in FAULT
//   state_o          current state encoding (0..4)
//   retry_cnt_o      timeout retries consumed since the last successful lock
//   lock_loss_cnt_o  saturating count of lock losses seen in RUNNING
//
// Build option:
//   LOCK_LOSS_COUNTER_EN  when defined, lock_loss_cnt_o is an 8-bit saturating
//                         counter of RUNNING->RST_PLL transitions caused by a
//                         lock loss. When undefined it is tied to zero and no
//                         counter flops exist.
//
// State encodings 5..7 are never produced; if one is ever held (upset), the
// next edge returns the machine to RST_PLL.
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYCLES    = 27,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 27000,
    parameter int unsigned STABLE_CYCLES       = 2700,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       pll_lock_i,
    input  logic       force_relock_i,
    input  logic       fault_clear_i,
    output logic       pll_reset_o,
    output logic       clk_ready_o,
    output logic       fault_o,
    output logic [2:0] state_o,
    output logic [3:0] retry_cnt_o,
    output logic [7:0] lock_loss_cnt_o
);

    // -------------------------------------------------------------------------
    // Counter sizing: one shared state timer wide enough for the largest
    // interval. It only ever needs to reach (interval - 1).
    // -------------------------------------------------------------------------
    localparam int unsigned MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int unsigned CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUNNING   = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    // Registers
    logic             sync_meta_q;
    logic             sync_lock_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       retry_q;
    logic             pll_reset_q;
    logic             clk_ready_q;
    logic             fault_q;

    // Next-state values
    state_e           state_d;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       retry_d;
    logic             pll_reset_d;
    logic             clk_ready_d;
    logic             fault_d;

    logic             lock_s;
    logic             relock_s;
    logic             restart_s;

    assign lock_s   = sync_lock_q;
    // force_relock acts everywhere except FAULT, where only fault_clear exits.
    assign relock_s = force_relock_i && (state_q != ST_FAULT);

    // Two-flop synchronizer for the asynchronous PLL LOCK output.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            sync_meta_q <= 1'b0;
            sync_lock_q <= 1'b0;
        end else begin
            sync_meta_q <= pll_lock_i;
            sync_lock_q <= sync_meta_q;
        end
    end

    // Next-state, retry bookkeeping and registered-output decode.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;

        if (relock_s) begin
            // Highest priority: overrides timeout, stabilize completion and
            // lock loss, and never consumes a retry.
            state_d = ST_RST_PLL;
        end else begin
            case (state_q)
                ST_RST_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        state_d = ST_RST_PLL;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABILIZE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q == RETRY_LIMIT) begin
                            state_d = ST_FAULT;
                        end else begin
                            retry_d = retry_q + 4'd1;
                            state_d = ST_RST_PLL;
                        end
                    end else begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_STABILIZE: begin
                    // A single dropped lock cycle restarts the whole wait; the
                    // retry budget is only spent on timeouts.
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUNNING;
                        retry_d = 4'd0;
                    end else begin
                        state_d = ST_STABILIZE;
                    end
                end
                ST_RUNNING: begin
                    if (!lock_s) begin
                        state_d = ST_RST_PLL;
                    end else begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_FAULT: begin
                    if (fault_clear_i) begin
                        state_d = ST_RST_PLL;
                        retry_d = 4'd0;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
                default: begin
                    state_d = ST_RST_PLL;
                end
            endcase
        end

        // The timer restarts on every state change and on a relock request
        // issued while already in RST_PLL (which lengthens the pulse).
        restart_s = relock_s || (state_d != state_q);
        if (restart_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // Outputs are decoded from the next state so that the registered
        // copies change on the same edge as the state register.
        pll_reset_d = (state_d == ST_RST_PLL) || (state_d == ST_FAULT);
        clk_ready_d = (state_d == ST_RUNNING);
        fault_d     = (state_d == ST_FAULT);
    end

    // State machine, timer and output registers.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q     <= ST_RST_PLL;
            cnt_q       <= {CNT_W{1'b0}};
            retry_q     <= 4'd0;
            pll_reset_q <= 1'b1;
            clk_ready_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            clk_ready_q <= clk_ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_reset_o = pll_reset_q;
    assign clk_ready_o = clk_ready_q;
    assign fault_o     = fault_q;
    assign state_o     = state_q;
    assign retry_cnt_o = retry_q;

`ifdef LOCK_LOSS_COUNTER_EN
    logic [7:0] lock_loss_q;
    logic       lock_loss_evt_s;

    // Only a genuine lock loss counts; a simultaneous force_relock takes the
    // transition and the event is not recorded.
    assign lock_loss_evt_s = (state_q == ST_RUNNING) && !lock_s && !force_relock_i;

    // Saturating lock-loss counter, cleared only by sys_rst.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            lock_loss_q <= 8'd0;
        end else if (lock_loss_evt_s && (lock_loss_q != 8'hFF)) begin
            lock_loss_q <= lock_loss_q + 8'd1;
        end else begin
            lock_loss_q <= lock_loss_q;
        end
    end

    assign lock_loss_cnt_o = lock_loss_q;
`else
    assign lock_loss_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Self-checking bench for pll_lock_supervisor. A behavioural model tracks the
// supervisor as a phase number plus time-in-phase, with the LOCK synchronizer
// represented as a short history queue of the raw pll_lock input. Directed
// scenarios cover the bring-up, glitch, timeout/fault, lock-loss, simultaneous
// event and asynchronous reset cases; a randomized run follows.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int P_RST  = 4;
    localparam int P_TO   = 20;
    localparam int P_ST   = 8;
    localparam int P_MAXR = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       force_relock = 1'b0;
    logic       fault_clear = 1'b0;
    logic       pll_reset;
    logic       clk_ready;
    logic       fault;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (P_RST),
        .LOCK_TIMEOUT_CYCLES(P_TO),
        .STABLE_CYCLES      (P_ST),
        .MAX_RETRIES        (P_MAXR)
    ) dut (
        .sys_clk_i      (sys_clk),
        .sys_rst_i      (sys_rst),
        .pll_lock_i     (pll_lock),
        .force_relock_i (force_relock),
        .fault_clear_i  (fault_clear),
        .pll_reset_o    (pll_reset),
        .clk_ready_o    (clk_ready),
        .fault_o        (fault),
        .state_o        (state),
        .retry_cnt_o    (retry_cnt),
        .lock_loss_cnt_o(lock_loss_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- behavioural model ----------------
    int   m_phase;
    int   m_tin;
    int   m_retry;
    int   m_loss;
    logic m_hist[$];

    function automatic void model_reset();
        m_phase = 0;
        m_tin   = 0;
        m_retry = 0;
        m_loss  = 0;
        m_hist.delete();
        m_hist.push_back(1'b0);
        m_hist.push_back(1'b0);
    endfunction

    // One active clock edge with the given inputs sampled.
    function automatic void model_step(input logic lock, input logic relock, input logic fclr);
        logic ls;
        int   nxt;
        bit   restart;
        m_hist.push_back(lock);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        ls      = m_hist[0];   // lock value seen two edges ago
        nxt     = m_phase;
        restart = 1'b0;
        if (relock && m_phase != 4) begin
            nxt     = 0;
            restart = 1'b1;
        end else begin
            case (m_phase)
                0: if (m_tin + 1 >= P_RST) nxt = 1;
                1: begin
                    if (ls) nxt = 2;
                    else if (m_tin + 1 >= P_TO) begin
                        if (m_retry == P_MAXR) nxt = 4;
                        else begin
                            m_retry = m_retry + 1;
                            nxt = 0;
                        end
                    end
                end
                2: begin
                    if (!ls) nxt = 1;
                    else if (m_tin + 1 >= P_ST) begin
                        nxt = 3;
                        m_retry = 0;
                    end
                end
                3: if (!ls) begin
                    nxt = 0;
                    if (m_loss < 255) m_loss = m_loss + 1;
                end
                4: if (fclr) begin
                    nxt = 0;
                    m_retry = 0;
                end
                default: nxt = 0;
            endcase
        end
        if (restart || nxt != m_phase) m_tin = 0;
        else m_tin = m_tin + 1;
        m_phase = nxt;
    endfunction

    function automatic int exp_loss();
`ifdef LOCK_LOSS_COUNTER_EN
        return m_loss;
`else
        return 0;
`endif
    endfunction

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, got, exp);
    endtask

    task automatic check_all();
        check_val("state",     32'(state),         32'(m_phase));
        check_val("pll_reset", 32'(pll_reset),     32'(m_phase == 0 || m_phase == 4));
        check_val("clk_ready", 32'(clk_ready),     32'(m_phase == 3));
        check_val("fault",     32'(fault),         32'(m_phase == 4));
        check_val("retry_cnt", 32'(retry_cnt),     32'(m_retry));
        check_val("lock_loss", 32'(lock_loss_cnt), 32'(exp_loss()));
    endtask

    // One clock cycle: drive inputs, step model on the edge, compare 1 ns later.
    task automatic cycle(input logic lock, input logic relock, input logic fclr);
        pll_lock     = lock;
        force_relock = relock;
        fault_clear  = fclr;
        @(posedge sys_clk);
        if (sys_rst) model_reset();
        else model_step(lock, relock, fclr);
        #1;
        cyc++;
        check_all();
    endtask

    // Hold lock high until RUNNING, bounded.
    task automatic run_to_running();
        int n = 0;
        while (m_phase != 3 && n < 200) begin
            cycle(1'b1, 1'b0, 1'b0);
            n++;
        end
        check_val("reach_running", 32'(m_phase == 3), 32'd1);
    endtask

    initial begin
        int  rise_at;
        int  edges;
        int  n;
        int  max_retry;
        bit  saw_back;
        int  retry_before;
        logic lk;
        int  hold;

        model_reset();

        // Reset state while sys_rst is held.
        #12;
        check_val("rst_state",     32'(state),         32'd0);
        check_val("rst_pll_reset", 32'(pll_reset),     32'd1);
        check_val("rst_clk_ready", 32'(clk_ready),     32'd0);
        check_val("rst_fault",     32'(fault),         32'd0);
        check_val("rst_retry",     32'(retry_cnt),     32'd0);
        check_val("rst_lock_loss", 32'(lock_loss_cnt), 32'd0);

        // 1. Nominal lock with pll_lock high from the first cycle.
        pll_lock = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        cyc = 0;
        rise_at = -1;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (i < P_RST - 1) check_val("t1_pll_reset_hi", 32'(pll_reset), 32'd1);
            if (i == P_RST - 1) check_val("t1_pll_reset_lo", 32'(pll_reset), 32'd0);
            if (clk_ready && rise_at < 0) rise_at = cyc;
        end
        check_val("t1_ready_cycle", 32'(rise_at), 32'(P_RST + 1 + P_ST));
        check_val("t1_retry", 32'(retry_cnt), 32'd0);

        // 2. One-cycle lock glitch at stable count 5.
        cycle(1'b1, 1'b1, 1'b0);
        n = 0;
        while (!(m_phase == 2 && m_tin == 5) && n < 100) begin
            cycle(1'b1, 1'b0, 1'b0);
            n++;
        end
        retry_before = m_retry;
        cycle(1'b0, 1'b0, 1'b0);
        saw_back = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (state == 3'd1) saw_back = 1'b1;
        end
        check_val("t2_back_to_wait", 32'(saw_back), 32'd1);
        edges = 0;
        while (!clk_ready && edges < 60) begin
            cycle(1'b1, 1'b0, 1'b0);
            edges++;
        end
        check_val("t2_ready_after_glitch", 32'(clk_ready), 32'd1);
        check_val("t2_retry_kept", 32'(retry_cnt), 32'(retry_before));

        // 3. Never locks: retries, FAULT, force_relock ignored, fault_clear.
        cycle(1'b0, 1'b1, 1'b0);
        max_retry = 0;
        n = 0;
        while (!fault && n < 300) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (int'(retry_cnt) > max_retry) max_retry = int'(retry_cnt);
            n++;
        end
        check_val("t3_max_retry", 32'(max_retry), 32'(P_MAXR));
        check_val("t3_fault", 32'(fault), 32'd1);
        check_val("t3_fault_pll_reset", 32'(pll_reset), 32'd1);
        cycle(1'b0, 1'b1, 1'b0);
        check_val("t5_relock_in_fault", 32'(state), 32'd4);
        cycle(1'b0, 1'b0, 1'b1);
        check_val("t3_clear_state", 32'(state), 32'd0);
        check_val("t3_clear_retry", 32'(retry_cnt), 32'd0);

        // 4. Lock loss in RUNNING: clk_ready low on the 3rd edge after drop.
        run_to_running();
        edges = 0;
        while (clk_ready && edges < 10) begin
            cycle(1'b0, 1'b0, 1'b0);
            edges++;
        end
        check_val("t4_drop_edges", 32'(edges), 32'd3);
        check_val("t4_state", 32'(state), 32'd0);
        for (int r = 0; r < 300; r++) begin
            run_to_running();
            n = 0;
            while (m_phase != 0 && n < 10) begin
                cycle(1'b0, 1'b0, 1'b0);
                n++;
            end
        end
`ifdef LOCK_LOSS_COUNTER_EN
        check_val("t4_saturate", 32'(lock_loss_cnt), 32'd255);
`else
        check_val("t4_tied_zero", 32'(lock_loss_cnt), 32'd0);
`endif

        // 5. force_relock on the stabilize-completion cycle.
        n = 0;
        while (!(m_phase == 2 && m_tin == P_ST - 1) && n < 100) begin
            cycle(1'b1, 1'b0, 1'b0);
            n++;
        end
        check_val("t5_reached_last", 32'(m_phase == 2 && m_tin == P_ST - 1), 32'd1);
        retry_before = int'(retry_cnt);
        cycle(1'b1, 1'b1, 1'b0);
        check_val("t5_state", 32'(state), 32'd0);
        check_val("t5_clk_ready", 32'(clk_ready), 32'd0);
        check_val("t5_retry", 32'(retry_cnt), 32'(retry_before));

        // 6. Async reset between edges while in WAIT_LOCK with a retry spent.
        n = 0;
        while (!(m_retry == 1 && m_phase == 1 && m_tin > 2) && n < 200) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
        check_val("t6_precondition", 32'(state), 32'd1);
        #3;
        sys_rst = 1'b1;
        #1;
        check_val("t6_pll_reset", 32'(pll_reset), 32'd1);
        check_val("t6_state", 32'(state), 32'd0);
        check_val("t6_retry", 32'(retry_cnt), 32'd0);
        model_reset();
        cycle(1'b0, 1'b0, 1'b0);
        sys_rst = 1'b0;

        // Randomized run against the model.
        lk = 1'b1;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                lk   = ($urandom_range(0, 3) != 0);
                hold = lk ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
            end
            hold--;
            cycle(lk, ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Sequences bring-up and recovery of the on-chip PLL (PLLVR, 27 MHz in, 120 MHz out).
- Drives the PLL RESET pin and watches the asynchronous LOCK output.
- Raises clk_ready only after lock has been continuously stable for a programmed interval.
- Retries a failed lock up to a bounded count, then parks in FAULT.
- Runs entirely on the 27 MHz board clock, never on the PLL output.

Parameters:
RST_PULSE_CYCLES, 27, PLL reset pulse length in sys_clk cycles (1 us); minimum 1
LOCK_TIMEOUT_CYCLES, 27000, max cycles to wait for lock after reset release (1 ms); minimum 2
STABLE_CYCLES, 2700, cycles lock must stay continuously high before ready (100 us); minimum 1
MAX_RETRIES, 3, timeout-driven reset retries before FAULT; 0..15

Ports:
sys_clk  in  1  27 MHz board clock; sole clock
sys_rst  in  1  asynchronous, active-high reset
pll_lock  in  1  raw PLL LOCK; asynchronous, synchronized internally
force_relock  in  1  single-cycle request to reset and relock the PLL
fault_clear  in  1  single-cycle request to leave FAULT
pll_reset  out  1  to PLL RESET; active-high
clk_ready  out  1  PLL clock valid; downstream reset release qualifier
fault  out  1  retries exhausted
state  out  3  current FSM state encoding
retry_cnt  out  4  timeout retries consumed since last successful lock
lock_loss_cnt  out  8  see Optional Feature

Behaviour:
- Synchronizer and counter
  - pll_lock passes through a 2-flop synchronizer to give lock_s; response to pll_lock is 2 cycles later.
  - A single down-counter or up-counter, sized $clog2 of the largest parameter, times every state.
  - The counter clears on every state transition.
- Reset values (asynchronous on sys_rst)
  - state=RST_PLL(0), pll_reset=1, clk_ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, synchronizer flops=0.
- All outputs are registered.
- RST_PLL (0)
  - pll_reset=1.
  - After RST_PULSE_CYCLES cycles in this state, go to WAIT_LOCK.
- WAIT_LOCK (1)
  - pll_reset=0.
  - If lock_s=1: go to STABILIZE.
  - Else on cycle LOCK_TIMEOUT_CYCLES-1:
    - if retry_cnt==MAX_RETRIES: go to FAULT;
    - otherwise retry_cnt+1 and go to RST_PLL.
- STABILIZE (2)
  - pll_reset=0.
  - If lock_s=0: return to WAIT_LOCK. The timeout restarts; retry_cnt is unchanged.
  - After STABLE_CYCLES consecutive lock_s=1 cycles: go to RUNNING and clear retry_cnt.
- RUNNING (3)
  - clk_ready=1.
  - If lock_s=0: go to RST_PLL. clk_ready is 0 from the same edge that enters RST_PLL.
  - A lock loss does not touch retry_cnt.
- FAULT (4)
  - pll_reset=1, fault=1, clk_ready=0.
  - Only fault_clear or sys_rst exits.
  - On fault_clear: retry_cnt=0, fault=0, go to RST_PLL.
- force_relock
  - In any state except FAULT, go to RST_PLL on the next edge. clk_ready=0 and the counter is cleared.
  - Ignored in FAULT.
  - In RST_PLL it restarts the pulse count.
- Simultaneous events
  - force_relock takes priority over timeout, stabilize completion and lock loss.
  - A force_relock-induced reset does not increment retry_cnt.
  - fault_clear outside FAULT is ignored.
- clk_ready timing: 1 exactly while state==RUNNING.
- Reset mid-operation: sys_rst at any time returns every output to its reset value immediately (asynchronous).
- Encodings 5-7 are unreachable. If entered, the FSM returns to RST_PLL on the next edge.

Optional Feature:
LOCK_LOSS_COUNTER_EN
- Defined:
  - lock_loss_cnt is an 8-bit saturating counter, +1 on each RUNNING->RST_PLL transition caused by lock_s=0. force_relock does not count.
  - Saturates at 255 and clears only on sys_rst.
- Undefined: lock_loss_cnt is tied to 0 and no counter flops are inferred.

Test Plan:
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Nominal lock: release sys_rst, pll_lock=1 from cycle 0 -> pll_reset high 4 cycles; clk_ready rises at the cycle count implied by WAIT_LOCK seeing lock_s (2-cycle sync) plus 8 stable cycles; retry_cnt=0.
2. Lock glitch during STABILIZE: drop pll_lock for 1 cycle at stable count 5 -> state back to 1, then 8 fresh stable cycles before clk_ready; retry_cnt unchanged.
3. Never locks: pll_lock=0 -> two timeouts, retry_cnt 1 then 2; third timeout enters FAULT with fault=1, pll_reset=1; fault_clear -> retry_cnt=0, state=0.
4. Lock loss in RUNNING: drop pll_lock -> clk_ready=0 on the 3rd edge after the drop, state=0; with LOCK_LOSS_COUNTER_EN, lock_loss_cnt=1. Repeat 300 times -> lock_loss_cnt stays 255.
5. Simultaneous events: force_relock on the same cycle as the STABILIZE completion -> state=RST_PLL, clk_ready stays 0, retry_cnt not incremented. force_relock in FAULT -> no change.
6. Async reset mid-WAIT_LOCK: pulse sys_rst between clock edges -> pll_reset=1, state=0, retry_cnt=0 immediately without a clock edge.
